// File: rtl/clk_break_ctrl.sv
// Breakpoint-driven clock-enable controller: gates a downstream clock enable
// by free-run, run-to-breakpoint, fixed-length step and halt commands.
module clk_break_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    active,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd_op,
    input  logic [WIDTH-1:0]        cmd_arg,
    output logic                    cmd_ready,
    input  logic [NUM_CH-1:0]       bp_en,
    input  logic [NUM_CH*WIDTH-1:0] bp_val,
    input  logic                    count_clr,
    output logic                    clk_en,
    output logic [WIDTH-1:0]        count,
    output logic [NUM_CH-1:0]       hit,
    output logic                    halted,
    output logic                    wrap
);

    typedef enum logic [2:0] {
        S_BYPASS,
        S_HALTED,
        S_RUN_FREE,
        S_RUN_BRK,
        S_STEP
    } state_t;

    localparam logic [1:0] OP_RUN_FREE = 2'b00;
    localparam logic [1:0] OP_RUN_BRK  = 2'b01;
    localparam logic [1:0] OP_STEP     = 2'b10;
    localparam logic [1:0] OP_HALT     = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   step_cnt_q, step_cnt_d;
    logic [NUM_CH-1:0]  hit_q, hit_d;
    logic               skip_q, skip_d;
    logic               wrap_q, wrap_d;
    logic [NUM_CH-1:0]  hit_now;
    logic               en_raw;
    logic               cmd_acc;

    // skip masks the compare on the first RUN_BRK cycle so a resume from a breakpoint advances
    always_comb begin
        hit_now = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit_now[i] = bp_en[i] && (count_q == bp_val[i*WIDTH +: WIDTH]) && !skip_q;
        end
    end

    always_comb begin
        en_raw = 1'b0;
        unique case (state_q)
            S_BYPASS, S_RUN_FREE, S_STEP: en_raw = 1'b1;
            S_RUN_BRK:                    en_raw = ~(|hit_now);
            default:                      en_raw = 1'b0;
        endcase
    end

    assign cmd_acc = cmd_valid && active;

    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        step_cnt_d = '0;
        skip_d     = 1'b0;
        if (!active) begin
            state_d = S_BYPASS;
        end else if (cmd_acc) begin
            unique case (cmd_op)
                OP_RUN_FREE: begin
                    state_d = S_RUN_FREE;
                    hit_d   = '0;
                end
                OP_RUN_BRK: begin
                    state_d = S_RUN_BRK;
                    hit_d   = '0;
                    skip_d  = 1'b1;
                end
                OP_STEP: begin
                    hit_d      = '0;
                    step_cnt_d = cmd_arg;
                    state_d    = (cmd_arg == '0) ? S_HALTED : S_STEP;
                end
                default: state_d = S_HALTED;
            endcase
        end else begin
            unique case (state_q)
                S_BYPASS: state_d = S_HALTED;
                S_RUN_BRK: begin
                    if (|hit_now) begin
                        hit_d   = hit_now;
                        state_d = S_HALTED;
                    end
                end
                S_STEP: begin
                    if (step_cnt_q <= WIDTH'(1)) begin
                        state_d = S_HALTED;
                    end else begin
                        step_cnt_d = step_cnt_q - WIDTH'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (count_clr) begin
            count_d = '0;
        end else if (en_raw) begin
            count_d = count_q + WIDTH'(1);
            wrap_d  = &count_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= S_BYPASS;
            count_q    <= '0;
            step_cnt_q <= '0;
            hit_q      <= '0;
            skip_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            step_cnt_q <= step_cnt_d;
            hit_q      <= hit_d;
            skip_q     <= skip_d;
            wrap_q     <= wrap_d;
        end
    end

    assign cmd_ready = active;
    assign clk_en    = en_raw & ~rst;
    assign count     = count_q;
    assign hit       = hit_q;
    assign halted    = (state_q == S_HALTED);
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_clk_break_ctrl.sv
// Directed bench for clk_break_ctrl: a 16-bit/4-channel instance for control
// behaviour and a 4-bit/1-channel instance for counter wrap.
module tb_clk_break_ctrl;

    logic        clk;
    logic        rst, active, cmd_valid, count_clr;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        cmd_ready, clk_en, halted, wrap;
    logic [3:0]  bp_en, hit;
    logic [63:0] bp_val;
    logic [15:0] count;

    logic        w_rst, w_active, w_cmd_valid, w_count_clr;
    logic [1:0]  w_cmd_op;
    logic [3:0]  w_cmd_arg, w_bp_val, w_count;
    logic        w_bp_en, w_hit;
    logic        w_cmd_ready, w_clk_en, w_halted, w_wrap;

    int checks   = 0;
    int failures = 0;
    int n;

    clk_break_ctrl #(.WIDTH(16), .NUM_CH(4)) dut (
        .clk_in(clk), .rst(rst), .active(active), .cmd_valid(cmd_valid),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_ready(cmd_ready),
        .bp_en(bp_en), .bp_val(bp_val), .count_clr(count_clr),
        .clk_en(clk_en), .count(count), .hit(hit), .halted(halted), .wrap(wrap)
    );

    clk_break_ctrl #(.WIDTH(4), .NUM_CH(1)) dut_w4 (
        .clk_in(clk), .rst(w_rst), .active(w_active), .cmd_valid(w_cmd_valid),
        .cmd_op(w_cmd_op), .cmd_arg(w_cmd_arg), .cmd_ready(w_cmd_ready),
        .bp_en(w_bp_en), .bp_val(w_bp_val), .count_clr(w_count_clr),
        .clk_en(w_clk_en), .count(w_count), .hit(w_hit), .halted(w_halted), .wrap(w_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_step(input logic [15:0] arg, output int cyc);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        #1;
        cyc = 0;
        while (!halted && cyc < 100) begin
            if (clk_en) cyc++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; active = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0;
        bp_en = '0; bp_val = '0; count_clr = 1'b0;
        w_rst = 1'b1; w_active = 1'b0; w_cmd_valid = 1'b0; w_cmd_op = 2'b00;
        w_cmd_arg = '0; w_bp_en = 1'b0; w_bp_val = '0; w_count_clr = 1'b0;

        tick();
        tick();
        check_eq("rst_count", count, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_wrap", wrap, 0);
        check_eq("rst_clk_en", clk_en, 0);

        // bypass counts freely
        rst = 1'b0;
        #1;
        for (int i = 0; i <= 4; i++) begin
            check_eq("byp_count", count, i);
            check_eq("byp_clk_en", clk_en, 1);
            if (i < 4) tick();
        end

        // run to breakpoint at 10
        active = 1'b1; count_clr = 1'b1; bp_en = 4'b0001; bp_val[15:0] = 16'd10;
        #1;
        check_eq("cmd_ready_hi", cmd_ready, 1);
        tick();
        count_clr = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01;
        #1;
        check_eq("clr_count", count, 0);
        check_eq("clr_halted", halted, 1);
        check_eq("halted_clk_en", clk_en, 0);
        tick();
        cmd_valid = 1'b0;
        #1;
        check_eq("brk_start_en", clk_en, 1);
        n = 0;
        while (clk_en && n < 30) begin
            tick();
            n++;
        end
        check_eq("brk10_count", count, 10);
        check_eq("brk10_clk_en", clk_en, 0);
        tick();
        check_eq("brk10_halted", halted, 1);
        check_eq("brk10_hit", hit, 4'b0001);
        check_eq("brk10_hold", count, 10);

        // resume from breakpoint, second channel at 12
        bp_en = 4'b0011; bp_val[31:16] = 16'd12; cmd_valid = 1'b1; cmd_op = 2'b01;
        tick();
        cmd_valid = 1'b0;
        #1;
        check_eq("res_hit_clr", hit, 0);
        check_eq("res_skip_en", clk_en, 1);
        check_eq("res_count10", count, 10);
        tick();
        check_eq("res_count11", count, 11);
        check_eq("res_en11", clk_en, 1);
        tick();
        check_eq("res_count12", count, 12);
        check_eq("res_en12", clk_en, 0);
        tick();
        check_eq("res_halted", halted, 1);
        check_eq("res_hit", hit, 4'b0010);

        // steps
        bp_en = 4'b0000;
        do_step(16'd8, n);
        check_eq("step8_cycles", n, 8);
        check_eq("step8_count", count, 20);
        check_eq("step8_hit_clr", hit, 0);
        do_step(16'd5, n);
        check_eq("step5_cycles", n, 5);
        check_eq("step5_count", count, 25);
        check_eq("step5_halted", halted, 1);
        do_step(16'd0, n);
        check_eq("step0_cycles", n, 0);
        check_eq("step0_count", count, 25);
        check_eq("step0_halted", halted, 1);

        // two channels matching the same value
        count_clr = 1'b1; bp_en = 4'b0101; bp_val[15:0] = 16'd7; bp_val[47:32] = 16'd7;
        tick();
        count_clr = 1'b0;
        #1;
        check_eq("multi_clr", count, 0);
        cmd_valid = 1'b1; cmd_op = 2'b01;
        tick();
        cmd_valid = 1'b0;
        #1;
        n = 0;
        while (clk_en && n < 30) begin
            tick();
            n++;
        end
        check_eq("multi_count", count, 7);
        tick();
        check_eq("multi_hit", hit, 4'b0101);
        check_eq("multi_halted", halted, 1);

        // run free then halt
        cmd_valid = 1'b1; cmd_op = 2'b00;
        tick();
        cmd_valid = 1'b0;
        #1;
        check_eq("free_hit_clr", hit, 0);
        check_eq("free_clk_en", clk_en, 1);
        check_eq("free_halted", halted, 0);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        tick();
        cmd_valid = 1'b0;
        #1;
        check_eq("halt_clk_en", clk_en, 0);
        check_eq("halt_halted", halted, 1);
        check_eq("halt_count", count, 8);

        // reset in the middle of a step
        bp_en = 4'b0000; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 16'd10;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check_eq("midstep_count", count, 10);
        rst = 1'b1;
        #1;
        check_eq("rst_cycle_en", clk_en, 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("mrst_count", count, 0);
        check_eq("mrst_hit", hit, 0);
        check_eq("mrst_halted", halted, 0);
        check_eq("mrst_wrap", wrap, 0);
        check_eq("mrst_bypass_en", clk_en, 1);
        tick();
        check_eq("mrst_to_halt", halted, 1);
        check_eq("mrst_count1", count, 1);

        // deactivate in the middle of run-to-breakpoint
        cmd_valid = 1'b1; cmd_op = 2'b01;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check_eq("rb_running_en", clk_en, 1);
        check_eq("rb_running_halted", halted, 0);
        active = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b11;
        #1;
        check_eq("cmd_ready_lo", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        #1;
        check_eq("deact_en", clk_en, 1);
        check_eq("deact_halted", halted, 0);
        tick();
        check_eq("ignored_halt_en", clk_en, 1);
        check_eq("ignored_halt_halted", halted, 0);

        // 4-bit instance: wrap behaviour
        w_rst = 1'b0; w_active = 1'b1;
        tick();
        check_eq("w_halted", w_halted, 1);
        check_eq("w_count1", w_count, 1);
        w_cmd_valid = 1'b1; w_cmd_op = 2'b10; w_cmd_arg = 4'd14;
        tick();
        w_cmd_valid = 1'b0;
        n = 0;
        while (!w_halted && n < 40) begin
            tick();
            n++;
        end
        check_eq("w_count15", w_count, 15);
        w_cmd_valid = 1'b1; w_cmd_op = 2'b00;
        tick();
        w_cmd_valid = 1'b0;
        #1;
        check_eq("w_pre_count", w_count, 15);
        check_eq("w_pre_wrap", w_wrap, 0);
        tick();
        check_eq("w_wrap_count", w_count, 0);
        check_eq("w_wrap_pulse", w_wrap, 1);
        tick();
        check_eq("w_post_count", w_count, 1);
        check_eq("w_post_wrap", w_wrap, 0);
        n = 0;
        while (w_count != 4'd15 && n < 40) begin
            tick();
            n++;
        end
        w_count_clr = 1'b1;
        tick();
        w_count_clr = 1'b0;
        #1;
        check_eq("w_clr_count", w_count, 0);
        check_eq("w_clr_nowrap", w_wrap, 0);
        tick();
        check_eq("w_clr_after", w_count, 1);
        check_eq("w_clr_after_wrap", w_wrap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_break_ctrl.md
CLK_BREAK_CTRL -- requirements
Module: clk_break_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the counter, compare-value and step-argument width.
REQ-002 SHALL have parameter NUM_CH, default 4, giving the number of breakpoint compare channels.
REQ-003 clk_in  input  1  sole clock, rising edge; one clock domain; reset is synchronous and active-high.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 active  input  1  0 = bypass (free-running enable), 1 = controlled operation.
REQ-006 cmd_valid  input  1  command strobe, sampled each rising edge.
REQ-007 cmd_op  input  2  00 RUN_FREE, 01 RUN_BRK, 10 STEP, 11 HALT.
REQ-008 cmd_arg  input  WIDTH  step length, used by STEP only.
REQ-009 cmd_ready  output  1  equal to active; commands are ignored while low.
REQ-010 bp_en  input  NUM_CH  per-channel breakpoint enable.
REQ-011 bp_val  input  NUM_CH*WIDTH  channel i compare value at bits [i*WIDTH +: WIDTH].
REQ-012 count_clr  input  1  synchronous counter clear.
REQ-013 clk_en  output  1  clock enable for downstream logic; combinational from state and compare.
REQ-014 count  output  WIDTH  number of enabled cycles, modulo 2^WIDTH.
REQ-015 hit  output  NUM_CH  registered channels that caused the last breakpoint halt.
REQ-016 halted  output  1  high while in HALTED.
REQ-017 wrap  output  1  one-cycle pulse on count overflow.

Function
REQ-018 States SHALL be BYPASS, HALTED, RUN_FREE, RUN_BRK, STEP.
REQ-019 clk_en SHALL be 1 in BYPASS, RUN_FREE and STEP; 0 in HALTED; in RUN_BRK, SHALL be NOT(OR of hit_now).
REQ-020 hit_now[i] SHALL be bp_en[i] AND (count == bp_val[i]) AND NOT skip.
REQ-021 A rising edge with clk_en=1 SHALL increment count by 1; count_clr=1 SHALL instead load 0, taking priority over the increment.
REQ-022 An increment from all-ones to 0 SHALL pulse wrap for exactly the next cycle; count_clr SHALL never assert wrap.
REQ-023 active=0 SHALL force BYPASS at the next edge from any state; BYPASS SHALL go to HALTED at the first edge with active=1.
REQ-024 A command SHALL be accepted at an edge with cmd_valid=1 and active=1; the new state SHALL take effect from the next cycle.
REQ-025 An accepted command SHALL override any current state, including mid-STEP or mid-RUN_BRK.
REQ-026 Priority SHALL be rst > active=0 > accepted command > breakpoint hit > step completion.
REQ-027 RUN_BRK entry SHALL set skip for exactly the first RUN_BRK cycle, so resuming at a breakpoint value advances at least one count.
REQ-028 In RUN_BRK, a cycle with any hit_now SHALL hold count, latch hit <= hit_now and go to HALTED at the next edge.
REQ-029 hit SHALL stay set until the next accepted RUN_FREE, RUN_BRK or STEP command clears it.
REQ-030 STEP SHALL load step_cnt <= cmd_arg and assert clk_en for exactly cmd_arg cycles, then enter HALTED.
REQ-031 cmd_arg=0 SHALL enter HALTED directly with zero enabled cycles.
REQ-032 HALT SHALL enter HALTED; clk_en SHALL be 0 from the cycle after acceptance.
REQ-033 Simultaneous matches on several channels SHALL set all of the corresponding hit bits.

Reset
REQ-034 rst=1 at an edge SHALL give, from the next cycle: state BYPASS, count 0, hit 0, halted 0, wrap 0, step_cnt 0, skip 0.
REQ-035 rst SHALL override every other input, including while in STEP or RUN_BRK.
REQ-036 clk_en SHALL be 0 during any cycle in which rst=1.

Verification
REQ-037 rst, then active=0 for 4 cycles -> clk_en=1 throughout; count 0,1,2,3,4.
REQ-038 active=1, count_clr, bp_en=0001, bp_val[0]=10, RUN_BRK -> count stops at 10 with clk_en=0 in that cycle, then halted=1, hit=0001.
REQ-039 From halt at 10, bp_en=0011, bp_val[1]=12, RUN_BRK -> count 11, then 12, then halt with hit=0010.
REQ-040 From count 20, STEP arg 5 -> exactly 5 clk_en cycles, count 25, halted=1; STEP arg 0 -> 0 cycles, count unchanged.
REQ-041 bp_val[0]=bp_val[2]=7, both enabled -> hit=0101; WIDTH=4 build, RUN_FREE from count 15 -> count 0, wrap high for one cycle.
REQ-042 rst mid-STEP -> REQ-034 values next cycle; active=0 mid-RUN_BRK -> BYPASS and clk_en=1 next cycle.
